pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the MIPS datapath. It is the common replacement for the per-stage IF/ID, ID/EX, EX/MEM and MEM/WB registers. It carries a control bundle and a data bundle with a valid bit, and supports stall (hold), flush (bubble injection) and automatic bubbling of invalid entries. It sits between adjacent pipeline stages and is driven by the hazard unit.

---
 rtl/pipe_pkg.sv | 57 +++++
 rtl/sat_counter32.sv | 33 +++
 rtl/pipe_stage_reg.sv | 92 +++++++++
 tb/tb_pipe_stage_reg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, per-stage control/data bundles and bubble constants for the MIPS pipeline registers.
// Latency: none (types and constants only).
// Backpressure: n/a; stall/flush handling lives in pipe_stage_reg.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    // ID/EX control: everything decode produces for the later stages.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } id_ex_ctrl_t;

    // EX/MEM control: memory/writeback controls plus the ALU zero flag for branch resolution.
    typedef struct packed {
        logic branch;
        logic mem_write;
        logic mem_read;
        logic reg_write;
        logic mem_to_reg;
        logic zero;
    } ex_mem_ctrl_t;

    // MEM/WB control: only writeback selection remains.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } mem_wb_ctrl_t;

    // EX/MEM data bundle: branch target, ALU result, store data and destination register.
    typedef struct packed {
        logic [WORD_W-1:0]     add_result;
        logic [WORD_W-1:0]     alu_result;
        logic [WORD_W-1:0]     read_data2;
        logic [REG_ADDR_W-1:0] dest_reg;
    } ex_mem_data_t;

    // A bubble never writes a register, touches memory or branches, so all-zero is the safe NOP.
    localparam id_ex_ctrl_t  ID_EX_CTRL_NOP  = '0;
    localparam ex_mem_ctrl_t EX_MEM_CTRL_NOP = '0;
    localparam mem_wb_ctrl_t MEM_WB_CTRL_NOP = '0;

    localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

    // Saturating increment used by the performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == SAT_MAX) ? SAT_MAX : val + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter with synchronous clear that sticks at all-ones instead of wrapping.
// Latency: count visible one cycle after the enabling edge.
// Backpressure: none; counts every enabled edge.
module sat_counter32
    import pipe_pkg::*;
(
    input  logic        Clk,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] cnt_out
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count: clear wins, otherwise saturating increment when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Count register.
    always_ff @(posedge Clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_out = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register (control + data + valid) with stall hold, flush bubble and auto-bubbling; optional perf counters under PIPE_STAGE_PERF_EN.
// Latency: 1 cycle, outputs purely registered.
// Backpressure: Stall_in holds contents and drops the incoming entry (upstream must stall too); Flush_in overrides stall and injects a bubble.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = $bits(ex_mem_ctrl_t),
    parameter int                DATA_W   = $bits(ex_mem_data_t),
    parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}}
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall_in,
    input  logic              Flush_in,
    input  logic              Valid_in,
    input  logic [CTRL_W-1:0] Ctrl_in,
    input  logic [DATA_W-1:0] Data_in,
    output logic              Valid_out,
    output logic [CTRL_W-1:0] Ctrl_out,
`ifdef PIPE_STAGE_PERF_EN
    output logic [DATA_W-1:0] Data_out,
    output logic [31:0]       StallCnt_out,
    output logic [31:0]       FlushCnt_out
`else
    output logic [DATA_W-1:0] Data_out
`endif
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Next-state: flush beats stall beats load. Data is left alone on flush since a
    // bubble's data is don't-care, and control is forced to NOP whenever the entry is invalid.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (Flush_in) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else if (!Stall_in) begin
            valid_d = Valid_in;
            ctrl_d  = Valid_in ? Ctrl_in : CTRL_NOP;
            data_d  = Data_in;
        end
    end

    // Stage state with synchronous reset to an empty bubble.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign Valid_out = valid_q;
    assign Ctrl_out  = ctrl_q;
    assign Data_out  = data_q;

`ifdef PIPE_STAGE_PERF_EN
    logic stall_evt;
    logic flush_evt;

    // A stall cycle only counts when it is not overridden by a flush; a flush only
    // counts when it actually squashes a real instruction.
    always_comb begin
        stall_evt = Stall_in & ~Flush_in;
        flush_evt = Flush_in & valid_q;
    end

    sat_counter32 u_stall_cnt (
        .Clk     (Clk),
        .clr     (Rst),
        .en      (stall_evt),
        .cnt_out (StallCnt_out)
    );

    sat_counter32 u_flush_cnt (
        .Clk     (Clk),
        .clr     (Rst),
        .en      (flush_evt),
        .cnt_out (FlushCnt_out)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios then random traffic against a behavioural model.
// Latency: checks one cycle after each driven edge.
// Backpressure: exercises stall/flush combinations including simultaneous assertion.
module tb_pipe_stage_reg;

    localparam int CW = 6;
    localparam int DW = 101;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Stall_in;
    logic          Flush_in;
    logic          Valid_in;
    logic [CW-1:0] Ctrl_in;
    logic [DW-1:0] Data_in;
    logic          Valid_out;
    logic [CW-1:0] Ctrl_out;
    logic [DW-1:0] Data_out;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   StallCnt_out;
    logic [31:0]   FlushCnt_out;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic          m_valid;
    logic [CW-1:0] m_ctrl;
    logic [DW-1:0] m_data;
    longint        m_stall_cnt;
    longint        m_flush_cnt;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_NOP(6'h00)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall_in     (Stall_in),
        .Flush_in     (Flush_in),
        .Valid_in     (Valid_in),
        .Ctrl_in      (Ctrl_in),
        .Data_in      (Data_in),
        .Valid_out    (Valid_out),
        .Ctrl_out     (Ctrl_out),
`ifdef PIPE_STAGE_PERF_EN
        .Data_out     (Data_out),
        .StallCnt_out (StallCnt_out),
        .FlushCnt_out (FlushCnt_out)
`else
        .Data_out     (Data_out)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] rand_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic check_all(input string tag);
        tests++;
        assert (Valid_out === m_valid) else begin
            fails++;
            $error("FAIL %s valid got %0b exp %0b", tag, Valid_out, m_valid);
        end
        tests++;
        assert (Ctrl_out === m_ctrl) else begin
            fails++;
            $error("FAIL %s ctrl got %h exp %h", tag, Ctrl_out, m_ctrl);
        end
        tests++;
        assert (Data_out === m_data) else begin
            fails++;
            $error("FAIL %s data got %h exp %h", tag, Data_out, m_data);
        end
        tests++;
        assert (Valid_out || (Ctrl_out === 6'h00)) else begin
            fails++;
            $error("FAIL %s invariant ctrl got %h exp 00 while invalid", tag, Ctrl_out);
        end
`ifdef PIPE_STAGE_PERF_EN
        tests++;
        assert (StallCnt_out === 32'(m_stall_cnt)) else begin
            fails++;
            $error("FAIL %s stall_cnt got %h exp %h", tag, StallCnt_out, 32'(m_stall_cnt));
        end
        tests++;
        assert (FlushCnt_out === 32'(m_flush_cnt)) else begin
            fails++;
            $error("FAIL %s flush_cnt got %h exp %h", tag, FlushCnt_out, 32'(m_flush_cnt));
        end
`endif
    endtask

    // Drive one cycle of inputs, update the model at the edge, check just after it.
    task automatic step(input logic rst, input logic stall, input logic flush,
                        input logic vld, input logic [CW-1:0] ctrl,
                        input logic [DW-1:0] data, input string tag);
        Rst      = rst;
        Stall_in = stall;
        Flush_in = flush;
        Valid_in = vld;
        Ctrl_in  = ctrl;
        Data_in  = data;
        @(posedge Clk);
        if (rst) begin
            m_valid = 1'b0; m_ctrl = '0; m_data = '0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (stall && !flush) m_stall_cnt = (m_stall_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall_cnt + 1;
            if (flush && m_valid) m_flush_cnt = (m_flush_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_flush_cnt + 1;
            if (flush) begin
                m_valid = 1'b0; m_ctrl = '0;
            end else if (!stall) begin
                m_valid = vld;
                m_ctrl  = vld ? ctrl : '0;
                m_data  = data;
            end
        end
        #1;
        check_all(tag);
    endtask

    logic [DW-1:0] all_ones;
    logic [DW-1:0] d_a, d_b, d0;

    initial begin
        all_ones = '1;
        m_valid = 1'b0; m_ctrl = '0; m_data = '0; m_stall_cnt = 0; m_flush_cnt = 0;
        Rst = 1'b1; Stall_in = 1'b0; Flush_in = 1'b0; Valid_in = 1'b1;
        Ctrl_in = 6'h3F; Data_in = all_ones;

        // Reset with aggressive inputs.
        step(1, 0, 0, 1, 6'h3F, all_ones, "reset0");
        step(1, 0, 0, 1, 6'h3F, all_ones, "reset1");

        // Load valid, then invalid entry auto-bubbles control but passes data.
        step(0, 0, 0, 1, 6'h15, 101'h1234, "load_valid");
        step(0, 0, 0, 0, 6'h3F, 101'h5678, "load_invalid");

        // Stall holds A for three cycles while inputs show B.
        d_a = rand_data();
        d_b = rand_data();
        step(0, 0, 0, 1, 6'h2A, d_a, "stall_loadA");
        step(0, 1, 0, 1, 6'h11, d_b, "stall1");
        step(0, 1, 0, 1, 6'h11, d_b, "stall2");
        step(0, 1, 0, 1, 6'h11, d_b, "stall3");
        step(0, 0, 0, 1, 6'h11, d_b, "stall_release_B");

        // Flush together with stall squashes, data holds; second flush on a bubble.
        d0 = rand_data();
        step(0, 0, 0, 1, 6'h15, d0, "flush_load");
        step(0, 1, 1, 1, 6'h3F, rand_data(), "flush_stall");
        step(0, 0, 1, 1, 6'h3F, rand_data(), "flush_bubble");

`ifdef PIPE_STAGE_PERF_EN
        // Saturation: preload the stall counter near the top.
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.cnt_q;
        m_stall_cnt = 64'hFFFF_FFFE;
        step(0, 1, 0, 0, 6'h00, rand_data(), "sat1");
        step(0, 1, 0, 0, 6'h00, rand_data(), "sat2");
        step(0, 1, 0, 0, 6'h00, rand_data(), "sat3");
`endif

        // Reset mid-stall, then loading resumes on the next edge.
        step(0, 0, 0, 1, 6'h0F, rand_data(), "rst_stall_loadA");
        step(0, 1, 0, 1, 6'h01, rand_data(), "rst_stall_hold");
        step(1, 1, 0, 1, 6'h01, rand_data(), "rst_mid_stall");
        step(0, 0, 0, 1, 6'h2C, rand_data(), "rst_resume");

        // Reset mid-flush.
        step(1, 0, 1, 1, 6'h3F, rand_data(), "rst_mid_flush");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
                 6'($urandom), rand_data(), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
